// File: rtl/level_filter_edges.sv
// -----------------------------------------------------------------------------
// level_filter_edges
//
// Per-bit debounce filter for slow control/status levels that are already
// synchronous to clk (or synchronised here when LEVEL_FILTER_EDGES_SYNC_EN is
// defined). Each bit of d_out changes only after its input has differed from
// the current d_out for STABLE_CYCLES consecutive qualified samples (tick=1).
// When a bit changes, a one-cycle rise or fall strobe is produced for that bit,
// and changed pulses once for the whole vector.
//
// There is no valid/ready handshake in this block: tick is a pure sample
// qualifier. When tick=0 nothing advances, and the strobes read 0.
//
// Parameters:
//   WIDTH          number of independent bits
//   STABLE_CYCLES  consecutive qualified samples needed to accept a new level
//                  (must be >= 1; 0 raises an elaboration-time $error)
//   INIT           reset value of d_out (and of the synchroniser stages)
//
// Ports:
//   clk      in   single clock; all logic on posedge
//   rst_n    in   asynchronous active-low reset
//   tick     in   sample qualifier
//   d_in     in   [WIDTH] level input
//   d_out    out  [WIDTH] filtered level
//   rise     out  [WIDTH] one-cycle pulse when d_out bit goes 0->1
//   fall     out  [WIDTH] one-cycle pulse when d_out bit goes 1->0
//   changed  out  OR of rise|fall, registered with the pulses
//
// Optional feature (macro LEVEL_FILTER_EDGES_SYNC_EN):
//   defined   -> d_in passes through a 2-flop per-bit synchroniser first,
//                adding 2 clocks of latency; d_in may be asynchronous.
//   undefined -> d_in feeds the filter directly.
// -----------------------------------------------------------------------------
module level_filter_edges #(
    parameter int               WIDTH         = 1,
    parameter int               STABLE_CYCLES = 4,
    parameter logic [WIDTH-1:0] INIT          = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    // Counter wide enough to hold 0 .. STABLE_CYCLES-1.
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    // Count value at which the next differing sample is accepted.
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    generate
        if (STABLE_CYCLES < 1) begin : g_bad_stable_cycles
            $error("level_filter_edges: STABLE_CYCLES must be >= 1");
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Input stage: optional 2-flop synchroniser
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] d_filt;

`ifdef LEVEL_FILTER_EDGES_SYNC_EN
    logic [WIDTH-1:0] sync_1;
    logic [WIDTH-1:0] sync_2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= INIT;
            sync_2 <= INIT;
        end else begin
            sync_1 <= d_in;
            sync_2 <= sync_1;
        end
    end

    assign d_filt = sync_2;
`else
    assign d_filt = d_in;
`endif

    // -------------------------------------------------------------------------
    // Filter state
    // -------------------------------------------------------------------------
    logic [CW-1:0]    cnt      [WIDTH];
    logic [CW-1:0]    cnt_next [WIDTH];
    logic [WIDTH-1:0] d_next;
    logic [WIDTH-1:0] rise_next;
    logic [WIDTH-1:0] fall_next;

    // Next-state logic. A sample that agrees with d_out clears the count, so
    // any glitch shorter than STABLE_CYCLES qualified samples leaves no trace.
    // The count is cleared when it reaches LAST and the level is accepted, so
    // it never exceeds STABLE_CYCLES-1 and needs no saturation.
    always_comb begin
        d_next    = d_out;
        rise_next = '0;
        fall_next = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_next[i] = cnt[i];
        end

        if (tick) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (d_filt[i] == d_out[i]) begin
                    cnt_next[i] = '0;
                end else if (cnt[i] == LAST) begin
                    d_next[i]    = d_filt[i];
                    cnt_next[i]  = '0;
                    rise_next[i] = d_filt[i];
                    fall_next[i] = ~d_filt[i];
                end else begin
                    cnt_next[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    // Strobes are recomputed every clock, so they always drop after one cycle
    // even when tick stays low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_out   <= INIT;
            rise    <= '0;
            fall    <= '0;
            changed <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            d_out   <= d_next;
            rise    <= rise_next;
            fall    <= fall_next;
            changed <= |(rise_next | fall_next);
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

endmodule

// File: tb/tb_level_filter_edges.sv
// -----------------------------------------------------------------------------
// tb_level_filter_edges
//
// Bench for level_filter_edges with WIDTH=4, STABLE_CYCLES=4, INIT=0.
// The driver applies inputs on the falling edge and pushes the expected
// outputs for the following rising edge into exp_q. A separate monitor pops
// one entry 1 ns after every rising edge and compares it with the DUT.
//
// The reference model keeps a sliding window of the most recent qualified
// samples: a bit flips when the last STABLE_CYCLES qualified samples taken
// since its previous change all differ from its current output.
// -----------------------------------------------------------------------------
module tb_level_filter_edges;

    localparam int         WIDTH  = 4;
    localparam int         STABLE = 4;
    localparam logic [3:0] INIT   = 4'b0000;
    localparam int         EW     = 3 * WIDTH + 1;

    // -------------------------------------------------------------------------
    // Clock / reset
    // -------------------------------------------------------------------------
    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             tick = 1'b0;
    logic [WIDTH-1:0] d_in = '0;
    logic [WIDTH-1:0] d_out;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             changed;

    always #5 clk = ~clk;

    level_filter_edges #(
        .WIDTH         (WIDTH),
        .STABLE_CYCLES (STABLE),
        .INIT          (INIT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick    (tick),
        .d_in    (d_in),
        .d_out   (d_out),
        .rise    (rise),
        .fall    (fall),
        .changed (changed)
    );

    // -------------------------------------------------------------------------
    // Scoreboard state
    // -------------------------------------------------------------------------
    logic [EW-1:0] exp_q[$];
    int            n_vec = 0;
    int            n_bad = 0;

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] m_out;
    logic [WIDTH-1:0] m_s1;
    logic [WIDTH-1:0] m_s2;
    logic [WIDTH-1:0] hist_q[$];
    int               since [WIDTH];

    task automatic model_reset();
        m_out = INIT;
        m_s1  = INIT;
        m_s2  = INIT;
        hist_q.delete();
        for (int i = 0; i < WIDTH; i++) since[i] = 0;
    endtask

    // Advances the model by one rising edge and returns the outputs it implies.
    task automatic model_step(input logic t, input logic [WIDTH-1:0] d,
                              output logic [EW-1:0] e);
        logic [WIDTH-1:0] v;
        logic [WIDTH-1:0] r;
        logic [WIDTH-1:0] f;
        logic             all_diff;
`ifdef LEVEL_FILTER_EDGES_SYNC_EN
        v    = m_s2;
        m_s2 = m_s1;
        m_s1 = d;
`else
        v = d;
`endif
        r = '0;
        f = '0;
        if (t) begin
            hist_q.push_back(v);
            if (hist_q.size() > STABLE) void'(hist_q.pop_front());
            for (int i = 0; i < WIDTH; i++) begin
                if (since[i] < STABLE) since[i]++;
                if (since[i] == STABLE) begin
                    all_diff = 1'b1;
                    for (int k = 0; k < hist_q.size(); k++) begin
                        if (hist_q[k][i] == m_out[i]) all_diff = 1'b0;
                    end
                    if (all_diff) begin
                        if (m_out[i]) f[i] = 1'b1;
                        else          r[i] = 1'b1;
                        m_out[i] = ~m_out[i];
                        since[i] = 0;
                    end
                end
            end
        end
        e = {m_out, r, f, |(r | f)};
    endtask

    // -------------------------------------------------------------------------
    // Driver tasks
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] cur_d = '0;

    task automatic drive_now(input logic t, input logic [WIDTH-1:0] d);
        logic [EW-1:0] e;
        tick  = t;
        d_in  = d;
        cur_d = d;
        model_step(t, d, e);
        exp_q.push_back(e);
    endtask

    task automatic step(input logic t, input logic [WIDTH-1:0] d);
        @(negedge clk);
        drive_now(t, d);
    endtask

    task automatic hold(input int n, input logic [WIDTH-1:0] d);
        for (int k = 0; k < n; k++) step(1'b1, d);
    endtask

    // Short asynchronous reset pulse between edges; outputs must drop at once.
    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        n_vec++;
        if ({d_out, rise, fall, changed} !== {INIT, {WIDTH{1'b0}}, {WIDTH{1'b0}}, 1'b0}) begin
            n_bad++;
            $display("FAIL async_reset: got d_out=%b rise=%b fall=%b changed=%b, want d_out=%b and no strobes",
                     d_out, rise, fall, changed, INIT);
        end
        #1;
        rst_n = 1'b1;
        model_reset();
        drive_now(1'b1, cur_d);
    endtask

    // -------------------------------------------------------------------------
    // Monitor
    // -------------------------------------------------------------------------
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if ({d_out, rise, fall, changed} !== e) begin
                    n_bad++;
                    $display("FAIL outputs @%0t: got d_out=%b rise=%b fall=%b changed=%b, want d_out=%b rise=%b fall=%b changed=%b",
                             $time, d_out, rise, fall, changed,
                             e[EW-1 -: WIDTH], e[EW-1-WIDTH -: WIDTH], e[WIDTH:1], e[0]);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        logic [WIDTH-1:0] rd;
        logic             rt;
        model_reset();

        // Reset state while rst_n is held low.
        #3;
        n_vec++;
        if ({d_out, rise, fall, changed} !== {INIT, {(2*WIDTH+1){1'b0}}}) begin
            n_bad++;
            $display("FAIL reset_state: got d_out=%b rise=%b fall=%b changed=%b", d_out, rise, fall, changed);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drive_now(1'b1, 4'b0000);
        hold(19, 4'b0000);

        // Bit 0 rises and is held.
        hold(8, 4'b0001);

        // Bit 1 glitch of 3 samples, then back low.
        hold(3, 4'b0011);
        hold(6, 4'b0001);

        // tick on every third clock, bit 2 held high.
        for (int k = 0; k < 18; k++) step((k % 3) == 2, 4'b0101);
        hold(2, 4'b0101);

        // Settle low, then all bits together up and down.
        hold(6, 4'b0000);
        hold(6, 4'b1111);
        hold(6, 4'b0000);

        // Bit 3 mid-count reset after two samples, then a fresh full count.
        hold(2, 4'b1000);
        pulse_reset();
        hold(6, 4'b1000);
        hold(6, 4'b0000);

        // Randomised phase: sparse toggles, random qualifier, rare resets.
        rd = cur_d;
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < WIDTH; i++) begin
                if ($urandom_range(0, 7) == 0) rd[i] = ~rd[i];
            end
            rt = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 299) == 0) begin
                cur_d = rd;
                pulse_reset();
            end else begin
                step(rt, rd);
            end
        end
        hold(10, rd);

        // Drain: every pushed expectation must have been checked.
        repeat (2) @(posedge clk);
        #2;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/level_filter_edges.md
Name: level_filter_edges

Overview:
- Downstream stage for a multi-bit level that has already been resampled into the local clock domain by a synchronizer.
- Each bit is debounced independently: the output changes only after the input has held a new value for STABLE_CYCLES consecutive qualified samples.
- Produces the filtered level, one-cycle rise and fall strobes per bit, and an aggregate change strobe.
- Used for slow control and status lines such as sensor flags and external triggers, before they reach the command and status logic.

Parameters:
- WIDTH, 1, number of independent bits.
- STABLE_CYCLES, 4, consecutive qualified samples required to accept a new level. Must be >= 1; 0 is illegal and triggers a simulation $error.
- INIT, 0 (WIDTH bits), reset value of d_out.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- tick  input  1  sample qualifier; tie to 1 to sample every clock, or drive from a prescaler.
- d_in  input  WIDTH  level input, already synchronous to clk.
- d_out  output  WIDTH  filtered level.
- rise  output  WIDTH  one-cycle pulse per bit when d_out goes 0->1.
- fall  output  WIDTH  one-cycle pulse per bit when d_out goes 1->0.
- changed  output  1  OR of (rise | fall), registered in the same cycle as the pulses.

Behaviour:
- Reset (rst_n=0, asynchronous): d_out=INIT, all counters=0, rise=fall=0, changed=0. Applying reset mid-count discards any partial count.
- Counter width: CW = clog2(STABLE_CYCLES+1), one counter per bit.
- Per bit i, at each posedge:
  - tick=0: counter and d_out hold; rise, fall and changed are 0.
  - tick=1 and d_in[i]==d_out[i]: counter cleared to 0. A glitch shorter than STABLE_CYCLES is fully rejected.
  - tick=1, d_in[i]!=d_out[i], and counter < STABLE_CYCLES-1: counter increments.
  - tick=1, d_in[i]!=d_out[i], and counter == STABLE_CYCLES-1: d_out[i] takes d_in[i], counter cleared to 0, and rise[i] or fall[i] asserts for exactly that cycle.
- The counter never exceeds STABLE_CYCLES-1, so no saturation logic is needed.
- Latency with tick=1: d_out follows a stable input change on the STABLE_CYCLES-th posedge that samples the new value.
  - STABLE_CYCLES=1 reduces to a single register with edge strobes.
- rise, fall and changed are registered. They assert in the same cycle that d_out shows the new value and deassert on the next clock, regardless of tick.
- Bits are fully independent. Simultaneous transitions on several bits produce simultaneous pulses and a single-cycle changed.
- An input that toggles back while counting clears the counter, and counting restarts from 0 on the next differing qualified sample.

Optional Feature:
- Macro: LEVEL_FILTER_EDGES_SYNC_EN.
- Defined: d_in passes through a 2-register per-bit synchronizer on clk before the filter. Both stages reset to INIT asynchronously. Latency grows by 2 clocks. d_in may then be asynchronous.
- Undefined: d_in feeds the filter directly, and the caller guarantees it is synchronous to clk.

Test Plan:
- Reset release, INIT=0, WIDTH=4, STABLE_CYCLES=4, d_in=0 -> d_out=0, rise=fall=0, changed=0 for 20 cycles.
- tick=1, d_in[0] 0->1 held -> d_out[0]=1 and rise[0]=1 on the 4th posedge sampling 1; rise[0]=0 the next cycle; changed pulses once.
- tick=1, d_in[1] high for 3 cycles then low -> d_out[1] stays 0; no pulses; counter returns to 0.
- tick asserted every 3rd clock, d_in[2] 0->1 held -> d_out[2] rises on the 4th qualified sample (about 12 clocks); rise[2] is exactly 1 clock wide.
- d_in=4'b1111 applied at once, then 4'b0000 after d_out settles -> rise=4'b1111 in one cycle, later fall=4'b1111 in one cycle; changed is a single pulse each time.
- rst_n pulsed low for a few ns mid-count, with 2 of 4 samples taken on bit 3 -> d_out returns to INIT immediately; after release the bit needs a full 4 fresh samples. With LEVEL_FILTER_EDGES_SYNC_EN defined, repeat the d_in[0] rise test -> rise[0] occurs 2 clocks later.
